// File: rtl/tug_pkg.sv
// rtl/tug_pkg.sv - shared types and constants for the tug-of-war playfield
package tug_pkg;

   typedef enum logic [1:0] {
      PLAY  = 2'd0,
      WIN_L = 2'd1,
      WIN_R = 2'd2
   } state_t;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_LEFT  = 2'b10;
   localparam logic [1:0] WIN_RIGHT = 2'b01;

   // Active-low segments ordered {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/seg7_digit.sv
// rtl/seg7_digit.sv - decimal digit to active-low seven-segment pattern
module seg7_digit
   import tug_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/tug_field.sv
// rtl/tug_field.sv - tug-of-war playfield: edge detect, marker FSM, scores, score digits
module tug_field
   import tug_pkg::*;
#(
   parameter  int NUM_LIGHTS = 9,
   parameter  int SCORE_MAX  = 7,
   localparam int SCORE_W    = $clog2(SCORE_MAX + 1)
)
(
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  L,
   input  logic                  R,
   output logic [NUM_LIGHTS-1:0] lights,
   output logic [1:0]            winner,
   output logic                  game_over,
   output logic [SCORE_W-1:0]    score_l,
   output logic [SCORE_W-1:0]    score_r,
   output logic [6:0]            hex_l,
   output logic [6:0]            hex_r
);

   localparam int POS_W = $clog2(NUM_LIGHTS);
   localparam logic [POS_W-1:0]   CENTRE = POS_W'((NUM_LIGHTS - 1) / 2);
   localparam logic [POS_W-1:0]   LAST   = POS_W'(NUM_LIGHTS - 1);
   localparam logic [SCORE_W-1:0] SMAX   = SCORE_W'(SCORE_MAX);

   logic               l_q, r_q;
   logic               press_l, press_r;
   state_t             state, state_n;
   logic [POS_W-1:0]   pos, pos_n;
   logic [SCORE_W-1:0] score_l_n, score_r_n;

   assign press_l = L & ~l_q;
   assign press_r = R & ~r_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         l_q     <= 1'b0;
         r_q     <= 1'b0;
         state   <= PLAY;
         pos     <= CENTRE;
         score_l <= '0;
         score_r <= '0;
      end else begin
         l_q     <= L;
         r_q     <= R;
         state   <= state_n;
         pos     <= pos_n;
         score_l <= score_l_n;
         score_r <= score_r_n;
      end
   end

   always_comb begin
      state_n   = state;
      pos_n     = pos;
      score_l_n = score_l;
      score_r_n = score_r;
      lights    = '0;
      winner    = WIN_NONE;
      game_over = 1'b0;
      case (state)
         PLAY: begin
            lights[pos] = 1'b1;
            // Simultaneous presses cancel; bounds are tested before any step
            if (press_l && !press_r) begin
               if (pos == LAST) begin
                  state_n = WIN_L;
                  if (score_l < SMAX) score_l_n = score_l + SCORE_W'(1);
               end else begin
                  pos_n = pos + POS_W'(1);
               end
            end else if (press_r && !press_l) begin
               if (pos == '0) begin
                  state_n = WIN_R;
                  if (score_r < SMAX) score_r_n = score_r + SCORE_W'(1);
               end else begin
                  pos_n = pos - POS_W'(1);
               end
            end
         end
         WIN_L, WIN_R: begin
            winner    = (state == WIN_L) ? WIN_LEFT : WIN_RIGHT;
            game_over = 1'b1;
            // Any press only starts the next round; it does not move the marker
            if (press_l || press_r) begin
               state_n = PLAY;
               pos_n   = CENTRE;
            end
         end
         default: begin
            state_n = PLAY;
            pos_n   = CENTRE;
         end
      endcase
   end

   seg7_digit u_hex_l (
      .digit (4'(score_l)),
      .seg   (hex_l)
   );

   seg7_digit u_hex_r (
      .digit (4'(score_r)),
      .seg   (hex_r)
   );

endmodule

// File: tb/tb_tug_field.sv
// tb/tb_tug_field.sv - directed and random checks of tug_field at 3, 9 and 15 lights
module tb_tug_field;

   logic Clock, Reset, L, R;

   logic [2:0]  lights3;
   logic [8:0]  lights9;
   logic [14:0] lights15;
   logic [1:0]  winner3, winner9, winner15;
   logic        go3, go9, go15;
   logic [2:0]  sl3, sr3, sl9, sr9, sl15, sr15;
   logic [6:0]  hl3, hr3, hl9, hr9, hl15, hr15;

   tug_field #(.NUM_LIGHTS(3)) u3 (
      .Clock(Clock), .Reset(Reset), .L(L), .R(R),
      .lights(lights3), .winner(winner3), .game_over(go3),
      .score_l(sl3), .score_r(sr3), .hex_l(hl3), .hex_r(hr3)
   );

   tug_field #(.NUM_LIGHTS(9)) u9 (
      .Clock(Clock), .Reset(Reset), .L(L), .R(R),
      .lights(lights9), .winner(winner9), .game_over(go9),
      .score_l(sl9), .score_r(sr9), .hex_l(hl9), .hex_r(hr9)
   );

   tug_field #(.NUM_LIGHTS(15)) u15 (
      .Clock(Clock), .Reset(Reset), .L(L), .R(R),
      .lights(lights15), .winner(winner15), .game_over(go15),
      .score_l(sl15), .score_r(sr15), .hex_l(hl15), .hex_r(hr15)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;

   // Reference model: 0 = playing, 1 = left has won, 2 = right has won
   int nl[3]    = '{3, 9, 15};
   int m_pos[3] = '{0, 0, 0};
   int m_st[3]  = '{0, 0, 0};
   int m_sl[3]  = '{0, 0, 0};
   int m_sr[3]  = '{0, 0, 0};
   bit m_lp[3]  = '{0, 0, 0};
   bit m_rp[3]  = '{0, 0, 0};

   logic [6:0] digit_seg[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit l, input bit r, input bit rst);
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            m_pos[k] = (nl[k] - 1) / 2;
            m_st[k] = 0; m_sl[k] = 0; m_sr[k] = 0;
            m_lp[k] = 0; m_rp[k] = 0;
         end else begin
            bit pl, pr;
            pl = l && !m_lp[k];
            pr = r && !m_rp[k];
            if (m_st[k] == 0) begin
               if (pl && !pr) begin
                  if (m_pos[k] == nl[k] - 1) begin
                     m_st[k] = 1;
                     m_sl[k] = (m_sl[k] >= 7) ? 7 : m_sl[k] + 1;
                  end else m_pos[k]++;
               end else if (pr && !pl) begin
                  if (m_pos[k] == 0) begin
                     m_st[k] = 2;
                     m_sr[k] = (m_sr[k] >= 7) ? 7 : m_sr[k] + 1;
                  end else m_pos[k]--;
               end
            end else if (pl || pr) begin
               m_st[k] = 0;
               m_pos[k] = (nl[k] - 1) / 2;
            end
            m_lp[k] = l;
            m_rp[k] = r;
         end
      end
   endtask

   task automatic check_inst(input int k, input logic [31:0] lt, input logic [31:0] wn,
                             input logic [31:0] go, input logic [31:0] sl, input logic [31:0] sr,
                             input logic [31:0] hl, input logic [31:0] hr);
      logic [31:0] exp_lt, exp_wn;
      exp_lt = (m_st[k] == 0) ? (32'd1 << m_pos[k]) : 32'd0;
      exp_wn = (m_st[k] == 1) ? 32'd2 : (m_st[k] == 2) ? 32'd1 : 32'd0;
      chk($sformatf("n%0d lights", nl[k]), lt, exp_lt);
      chk($sformatf("n%0d winner", nl[k]), wn, exp_wn);
      chk($sformatf("n%0d game_over", nl[k]), go, (m_st[k] != 0) ? 32'd1 : 32'd0);
      chk($sformatf("n%0d score_l", nl[k]), sl, 32'(m_sl[k]));
      chk($sformatf("n%0d score_r", nl[k]), sr, 32'(m_sr[k]));
      chk($sformatf("n%0d hex_l", nl[k]), hl, 32'(digit_seg[m_sl[k]]));
      chk($sformatf("n%0d hex_r", nl[k]), hr, 32'(digit_seg[m_sr[k]]));
   endtask

   task automatic tick(input bit l, input bit r, input bit rst);
      L = l; R = r; Reset = rst;
      @(posedge Clock);
      model_step(l, r, rst);
      @(negedge Clock);
      check_inst(0, 32'(lights3), 32'(winner3), 32'(go3), 32'(sl3), 32'(sr3), 32'(hl3), 32'(hr3));
      check_inst(1, 32'(lights9), 32'(winner9), 32'(go9), 32'(sl9), 32'(sr9), 32'(hl9), 32'(hr9));
      check_inst(2, 32'(lights15), 32'(winner15), 32'(go15), 32'(sl15), 32'(sr15), 32'(hl15), 32'(hr15));
   endtask

   task automatic press(input bit l, input bit r);
      tick(l, r, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      L = 1'b0; R = 1'b0; Reset = 1'b1;

      tick(0, 0, 1); tick(0, 0, 1);
      chk("reset lights", 32'(lights9), 32'b000010000);
      chk("reset winner", 32'(winner9), 32'd0);
      chk("reset scores", 32'({sl9, sr9}), 32'd0);
      chk("reset hex_l", 32'(hl9), 32'b1000000);
      chk("reset hex_r", 32'(hr9), 32'b1000000);

      repeat (10) tick(1, 0, 0);
      chk("held L one move", 32'(lights9), 32'b000100000);
      tick(0, 0, 0);
      tick(1, 0, 0);
      chk("second L press", 32'(lights9), 32'b001000000);

      tick(0, 0, 1);
      for (int p = 1; p <= 5; p++) begin
         press(1, 0);
         if (p == 4) chk("4th press leftmost", 32'(lights9), 32'b100000000);
      end
      chk("win lights off", 32'(lights9), 32'd0);
      chk("win winner", 32'(winner9), 32'b10);
      chk("win game_over", 32'(go9), 32'd1);
      chk("win score_l", 32'(sl9), 32'd1);
      chk("win hex_l", 32'(hl9), 32'b1111001);
      press(0, 1);
      chk("restart lights", 32'(lights9), 32'b000010000);
      chk("restart score_r", 32'(sr9), 32'd0);

      press(1, 0);
      tick(1, 1, 0);
      chk("both press same edge", 32'(lights9), 32'b000100000);
      tick(0, 0, 0);
      chk("both press next cycle", 32'(lights9), 32'b000100000);

      tick(0, 0, 1);
      for (int w = 1; w <= 8; w++) begin
         if (w > 1) press(1, 0);
         repeat (5) press(1, 0);
      end
      chk("sat score_l", 32'(sl9), 32'd7);
      chk("sat hex_l", 32'(hl9), 32'b1111000);
      chk("sat winner", 32'(winner9), 32'b10);

      tick(0, 0, 1);
      for (int w = 1; w <= 3; w++) begin
         if (w > 1) press(0, 1);
         repeat (5) press(0, 1);
      end
      chk("winr score_r", 32'(sr9), 32'd3);
      chk("winr winner", 32'(winner9), 32'b01);
      tick(0, 0, 1);
      chk("reset from win lights", 32'(lights9), 32'b000010000);
      chk("reset from win scores", 32'({sl9, sr9}), 32'd0);

      chk("n3 centre", 32'(lights3), 32'b010);
      chk("n15 centre", 32'(lights15), 32'b000000010000000);
      for (int p = 1; p <= 8; p++) begin
         press(0, 1);
         if (p == 2) chk("n3 right win", 32'(winner3), 32'b01);
         if (p == 7) chk("n15 not yet", 32'(winner15), 32'b00);
         if (p == 8) chk("n15 right win", 32'(winner15), 32'b01);
      end

      repeat (600) begin
         bit rl, rr, rs;
         rl = ($urandom_range(0, 2) != 0);
         rr = ($urandom_range(0, 2) == 0);
         rs = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 1) == 1) begin
            rl = ($urandom_range(0, 3) == 0);
            rr = ($urandom_range(0, 2) != 0);
         end
         tick(rl, rr, rs);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
